// File: rtl/xz_scrub_buffer.sv
// xz_scrub_buffer
// Multi-lane FIFO bridging 4-state producers to 2-state consumers. Each pushed
// lane has its X/Z bits replaced by SCRUB_VAL, is then XORed with the lane's
// inversion bit, and is stored with a per-lane "had X/Z" flag.
//
// Optional feature macro: XZ_SCRUB_STATS_EN (per-lane saturating X/Z counters).
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     producer word valid (X/Z here blocks the push, sets ctrl_xz)
//   in_ready     buffer can accept a word
//   in_data      4-state lane data
//   inv_mask     per-lane invert, sampled with the word
//   out_valid    head entry valid
//   out_ready    consumer takes the head
//   out_data     scrubbed, inverted head data
//   out_xz       per-lane X/Z flag of the head entry
//   level        occupancy
//   ctrl_xz      sticky flag: in_valid was X/Z on some cycle
//   stats_clr    clears stats_count
//   stats_count  per-lane count of pushes that carried X/Z
module xz_scrub_buffer #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter bit          SCRUB_VAL = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output bit                                  in_ready,
  input  logic [CHANNELS-1:0][WIDTH-1:0]      in_data,
  input  bit   [CHANNELS-1:0]                 inv_mask,
  output bit                                  out_valid,
  input  logic                                out_ready,
  output bit   [CHANNELS-1:0][WIDTH-1:0]      out_data,
  output bit   [CHANNELS-1:0]                 out_xz,
  output logic [$clog2(DEPTH):0]              level,
  output logic                                ctrl_xz,
  input  logic                                stats_clr,
  output logic [CHANNELS-1:0][15:0]           stats_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  bit   [CHANNELS-1:0][WIDTH-1:0] r_mem [DEPTH];
  bit   [CHANNELS-1:0]            r_xz_mem [DEPTH];
  logic [AW-1:0]                  r_wr_ptr;
  logic [AW-1:0]                  r_rd_ptr;
  logic [LW-1:0]                  r_level;
  logic                           r_ctrl_xz;

  bit   [CHANNELS-1:0][WIDTH-1:0] w_scrub;
  bit   [CHANNELS-1:0]            w_lane_xz;
  logic                           w_push;
  logic                           w_pop;

  // Only a clean 1 on in_valid counts; in_ready already folds in rst.
  assign in_ready  = !rst && (r_level != LW'(DEPTH));
  assign out_valid = (r_level != '0);
  assign w_push    = (in_valid === 1'b1) && in_ready;
  assign w_pop     = out_valid && (out_ready === 1'b1) && !rst;

  assign out_data = r_mem[r_rd_ptr];
  assign out_xz   = r_xz_mem[r_rd_ptr];
  assign level    = r_level;
  assign ctrl_xz  = r_ctrl_xz;

  // Scrub each bit to a 2-state value, then apply the lane inversion.
  always_comb begin
    w_scrub   = '0;
    w_lane_xz = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      w_lane_xz[c] = $isunknown(in_data[c]);
      for (int unsigned b = 0; b < WIDTH; b++) begin
        if (in_data[c][b] === 1'b1)      w_scrub[c][b] = 1'b1 ^ inv_mask[c];
        else if (in_data[c][b] === 1'b0) w_scrub[c][b] = 1'b0 ^ inv_mask[c];
        else                             w_scrub[c][b] = SCRUB_VAL ^ inv_mask[c];
      end
    end
  end

  // FIFO storage, pointers and occupancy. Storage is cleared on reset so a
  // discarded word can never resurface on out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ctrl_xz <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i]    <= '0;
        r_xz_mem[i] <= '0;
      end
    end else begin
      if ($isunknown(in_valid)) r_ctrl_xz <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr]    <= w_scrub;
        r_xz_mem[r_wr_ptr] <= w_lane_xz;
        r_wr_ptr           <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef XZ_SCRUB_STATS_EN
  logic [CHANNELS-1:0][15:0] r_stats;

  // Saturating per-lane X/Z counters; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stats <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (stats_clr === 1'b1)
          r_stats[c] <= '0;
        else if (w_push && w_lane_xz[c] && (r_stats[c] != 16'hFFFF))
          r_stats[c] <= r_stats[c] + 16'd1;
      end
    end
  end

  assign stats_count = r_stats;
`else
  logic w_unused_stats_clr;
  assign w_unused_stats_clr = stats_clr;
  assign stats_count        = '0;
`endif

endmodule

// File: tb/tb_xz_scrub_buffer.sv
module tb_xz_scrub_buffer;

  logic              clk;
  logic              rst;
  logic              in_valid;
  bit                in_ready;
  logic [1:0][3:0]   in_data;
  bit   [1:0]        inv_mask;
  bit                out_valid;
  logic              out_ready;
  bit   [1:0][3:0]   out_data;
  bit   [1:0]        out_xz;
  logic [2:0]        level;
  logic              ctrl_xz;
  logic              stats_clr;
  logic [1:0][15:0]  stats_count;

  int errors;
  int checks;
  bit sim4;   // simulator keeps X/Z distinct from 0/1

  xz_scrub_buffer #(.CHANNELS(2), .WIDTH(4), .DEPTH(4), .SCRUB_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .inv_mask(inv_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_xz(out_xz),
    .level(level), .ctrl_xz(ctrl_xz), .stats_clr(stats_clr),
    .stats_count(stats_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled at negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; stats_clr = 1'b0;
    in_data = '0; inv_mask = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level got=%0d exp=0", level); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
    checks++; if (out_xz !== 2'b00) begin errors++; $display("FAIL rst_out_xz got=%b exp=00", out_xz); end
    checks++; if (ctrl_xz !== 1'b0) begin errors++; $display("FAIL rst_ctrl_xz got=%b exp=0", ctrl_xz); end
    checks++; if (stats_count !== 32'h0) begin errors++; $display("FAIL rst_stats got=%h exp=0", stats_count); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_scrub();
    logic [3:0] l1;
    logic [3:0] exp_l1;
    in_data = {4'b1x0z, 4'b0101}; inv_mask = 2'b01; in_valid = 1'b1;
    l1 = in_data[1];
    exp_l1 = sim4 ? 4'b1000 : l1;
    step();
    in_valid = 1'b0; inv_mask = 2'b00;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL scrub_level got=%0d exp=1", level); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL scrub_out_valid got=%0b exp=1", out_valid); end
    checks++; if (out_data[0] !== 4'b1010) begin errors++; $display("FAIL scrub_lane0 got=%b exp=1010", out_data[0]); end
    checks++; if (out_data[1] !== exp_l1) begin errors++; $display("FAIL scrub_lane1 got=%b exp=%b", out_data[1], exp_l1); end
    checks++; if (out_xz !== (sim4 ? 2'b10 : 2'b00)) begin errors++; $display("FAIL scrub_xz got=%b exp=%b", out_xz, sim4 ? 2'b10 : 2'b00); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL scrub_pop level=%0d valid=%0b exp 0/0", level, out_valid); end
  endtask

  task automatic test_full();
    logic [7:0] w [4];
    w[0] = 8'h18; w[1] = 8'h29; w[2] = 8'h3A; w[3] = 8'h4B;
    for (int i = 0; i < 4; i++) begin
      in_data = w[i]; in_valid = 1'b1;
      step();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    in_data = 8'hFF;
    step();
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL full_reject got=%0d exp=4", level); end
    checks++; if (out_data !== w[0]) begin errors++; $display("FAIL full_hold got=%h exp=%h", out_data, w[0]); end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL full_pop_level got=%0d exp=3", level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%0b exp=1", in_ready); end
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== w[i]) begin errors++; $display("FAIL full_order%0d got=%h v=%0b exp=%h", i, out_data, out_valid, w[i]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v [10];
    for (int i = 0; i < 10; i++) v[i] = {4'(i), 4'(15 - i)};
    out_ready = 1'b1;
    in_data = v[0]; in_valid = 1'b1;
    step();
    checks++; if (level !== 3'd1 || out_data !== v[0]) begin errors++; $display("FAIL b2b_first level=%0d data=%h exp 1/%h", level, out_data, v[0]); end
    for (int i = 1; i < 10; i++) begin
      in_data = v[i];
      step();
      checks++; if (out_valid !== 1'b1 || level !== 3'd1 || out_data !== v[i]) begin
        errors++; $display("FAIL b2b_word%0d data=%h level=%0d v=%0b exp=%h/1/1", i, out_data, level, out_valid, v[i]);
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_drain got=%0d exp=0", level); end
  endtask

  task automatic test_ctrl_xz();
    logic pv;
    in_data = 8'h33; in_valid = 1'bx;
    pv = in_valid;
    step();
    in_valid = 1'b0;
    checks++; if (level !== ((!sim4 && pv === 1'b1) ? 3'd1 : 3'd0)) begin errors++; $display("FAIL ctrlxz_level got=%0d", level); end
    checks++; if (ctrl_xz !== sim4) begin errors++; $display("FAIL ctrlxz_set got=%b exp=%b", ctrl_xz, sim4); end
    if (level != 3'd0) begin
      out_ready = 1'b1; step(); out_ready = 1'b0;
    end
    step(); step();
    checks++; if (ctrl_xz !== sim4) begin errors++; $display("FAIL ctrlxz_sticky got=%b exp=%b", ctrl_xz, sim4); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      in_data = {2{4'(10 + i)}}; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b0) begin errors++; $display("FAIL midrst_state v=%0b level=%0d rdy=%0b exp 0/0/0", out_valid, level, in_ready); end
    checks++; if (out_data !== 8'h00 || ctrl_xz !== 1'b0) begin errors++; $display("FAIL midrst_data data=%h ctrl=%b exp 00/0", out_data, ctrl_xz); end
    rst = 1'b0;
    in_data = 8'h56; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (level !== 3'd1 || out_data !== 8'h56) begin errors++; $display("FAIL midrst_new level=%0d data=%h exp 1/56", level, out_data); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    checks++; if (level !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale level=%0d v=%0b exp 0/0", level, out_valid); end
  endtask

  task automatic test_stats();
    logic [15:0] exp3;
    logic [15:0] expsat;
`ifdef XZ_SCRUB_STATS_EN
    exp3   = sim4 ? 16'd3 : 16'd0;
    expsat = sim4 ? 16'hFFFF : 16'd0;
`else
    exp3   = 16'd0;
    expsat = 16'd0;
`endif
    out_ready = 1'b1;
    in_data = {4'b0z10, 4'b0011}; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    checks++; if (stats_count[1] !== exp3) begin errors++; $display("FAIL stats_lane1 got=%0d exp=%0d", stats_count[1], exp3); end
    checks++; if (stats_count[0] !== 16'd0) begin errors++; $display("FAIL stats_lane0 got=%0d exp=0", stats_count[0]); end
    in_valid = 1'b1; stats_clr = 1'b1;
    step();
    stats_clr = 1'b0; in_valid = 1'b0;
    checks++; if (stats_count[1] !== 16'd0) begin errors++; $display("FAIL stats_clr got=%0d exp=0", stats_count[1]); end
`ifdef XZ_SCRUB_STATS_EN
    in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    in_valid = 1'b0;
    checks++; if (stats_count[1] !== expsat) begin errors++; $display("FAIL stats_reach_max got=%h exp=%h", stats_count[1], expsat); end
`endif
    in_valid = 1'b1;
    step(); step();
    in_valid = 1'b0;
    checks++; if (stats_count[1] !== expsat) begin errors++; $display("FAIL stats_saturate got=%h exp=%h", stats_count[1], expsat); end
    step();
    out_ready = 1'b0;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL stats_drain got=%0d exp=0", level); end
  endtask

  initial begin
    logic probe;
    errors = 0; checks = 0;
    probe = 1'bx;
    sim4 = (probe !== 1'b0) && (probe !== 1'b1);
    test_reset();
    test_scrub();
    test_full();
    test_back_to_back();
    test_ctrl_xz();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xz_scrub_buffer.md
# xz_scrub_buffer

Parametrised multi-channel buffer that takes 4-state packed-array lanes, scrubs X/Z bits to a fixed 2-state value, applies a per-channel inversion mask, and queues the result in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It generalises the fixed-width single-inverter port adapters to CHANNELS lanes of WIDTH bits. It sits between 4-state (logic/tri) producers and 2-state (bit) consumers, and it flags every lane that carried X/Z.

## Interface
- CHANNELS, default 2: number of lanes, ≥1.
- WIDTH, default 4: bits per lane, ≥1.
- DEPTH, default 4: FIFO entries; power of 2, ≥2.
- SCRUB_VAL, default 1'b0: value that replaces any X/Z input bit.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1 (logic)  producer has a word.
- in_ready  output  1 (bit)  buffer can accept a word.
- in_data  input  logic [CHANNELS-1:0][WIDTH-1:0]  4-state lane data.
- inv_mask  input  bit [CHANNELS-1:0]  per-lane invert; sampled with the word.
- out_valid  output  1 (bit)  head entry is valid.
- out_ready  input  1  consumer takes the head.
- out_data  output  bit [CHANNELS-1:0][WIDTH-1:0]  scrubbed, inverted head data.
- out_xz  output  bit [CHANNELS-1:0]  per-lane flag of the head: the lane had ≥1 X/Z bit.
- level  output  $clog2(DEPTH)+1  occupancy.
- ctrl_xz  output  1  sticky; in_valid was X/Z on some cycle.
- stats_clr  input  1  clears stats_count.
- stats_count  output  [CHANNELS-1:0][15:0]  per-lane X/Z word counters.

## Operation
- Push: a push occurs when in_valid===1 and in_ready==1. For each bit, X/Z becomes SCRUB_VAL; the result is then XORed with {WIDTH{inv_mask[c]}}. out_xz[c] records whether the raw lane had any X/Z bit.
- in_valid X/Z: no push occurs, and ctrl_xz is set. ctrl_xz stays set until rst.
- Pop: a pop occurs when out_valid && out_ready. The read pointer advances.
- in_ready = (level != DEPTH) and !rst. It does not depend on out_ready, so there is no combinational path from out_ready to in_ready.
- out_valid = (level != 0).
  - out_data and out_xz are driven from the head entry.
  - They hold stable while out_valid && !out_ready.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- level rules:
  - Push and pop in the same cycle: level unchanged.
  - Push only: level+1.
  - Pop only: level−1.
- There is no empty bypass.
- While rst is high, out_ready and in_valid are ignored.

## Timing
- Reset values (asserted in the cycle after rst is sampled high, and held while rst is high):
  - in_ready=0, out_valid=0, out_data=0, out_xz=0, level=0, ctrl_xz=0, stats_count=0.
  - in_ready rises in the first cycle after rst deasserts.
- Latency: a word pushed at edge N is on out_data with out_valid=1 after edge N, i.e. available to pop at edge N+1.
- Throughput: 1 word/cycle when 0<level<DEPTH.
- Full: a pop at edge N raises in_ready after edge N. A same-cycle push is impossible.
- Empty: a push and a pop cannot coincide.
- Reset mid-operation: all entries are discarded. Stale data must not reappear.

## Configuration
- Macro XZ_SCRUB_STATS_EN.
- Defined:
  - stats_count[c] increments by 1 on each push where lane c had any X/Z bit, saturating at 16'hFFFF.
  - stats_clr zeroes all counters. If stats_clr coincides with an increment, the counter is zeroed (clear wins).
- Undefined: stats_count is constant 0, stats_clr is ignored, and no counter flops are synthesised. All other behaviour is identical.

## Test plan
- Reset, then push in_data={4'b1x0z,4'b0101}, inv_mask=2'b01 with SCRUB_VAL=0 → next cycle out_data={4'b1000,4'b1010}, out_xz=2'b10, level=1.
- Push 4 words with out_ready=0 → level=4, in_ready=0. A 5th in_valid is not accepted. One pop → in_ready=1 next cycle, and order is preserved FIFO.
- Continuous push/pop for 10 words across pointer wrap → 10 outputs in order, level stays 1, no bubbles after the first.
- Drive in_valid=1'bx for one cycle → no push, level unchanged, ctrl_xz=1 and it remains set until rst.
- Fill with 3 words, assert rst for 1 cycle → out_valid=0, level=0. The post-reset push emits only new data.
- With XZ_SCRUB_STATS_EN: 3 pushes with lane1 containing z → stats_count[1]=3, stats_count[0]=0. stats_clr concurrent with a 4th such push → 0. Preload 16'hFFFF → it stays at FFFF. Without the macro → stats_count always 0.
